// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle MIPS control FSM and the datapath.
// The controller takes the master view; the datapath (or a bench) takes the slave view.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       OP;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemToReg;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUsrcA;
  logic [1:0]       ALUsrcB;
  logic [1:0]       ALUop;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  OP, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite,
           RegDst, ALUsrcA, ALUsrcB, ALUop, PCSource, state, instr_done, illegal, instr_count
  );

  modport slave (
    output OP, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite,
           RegDst, ALUsrcA, ALUsrcB, ALUop, PCSource, state, instr_done, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main control FSM: sequences R/LW/SW/BEQ/J through shared memory and ALU,
// decodes datapath controls from the current state and counts retired instructions.
module multicycle_controller #(
  parameter int unsigned CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.master bus
);
  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpJ   = 6'b000010;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9
  } state_e;

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_done) r_count <= r_count + CNT_W'(1);
    end
  end

  // Codes 10-15 fall into the default arm and recover to FETCH.
  always_comb begin
    w_next = StFetch;
    case (r_state)
      StFetch:    w_next = bus.mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (bus.OP)
          OpR:        w_next = StExecute;
          OpLw, OpSw: w_next = StMemAddr;
          OpBeq:      w_next = StBranch;
          OpJ:        w_next = StJump;
          default:    w_next = StFetch;
        endcase
      end
      StMemAddr: begin
        if (bus.OP == OpLw)      w_next = StMemRead;
        else if (bus.OP == OpSw) w_next = StMemWrite;
        else                     w_next = StFetch;
      end
      StMemRead:  w_next = bus.mem_ready ? StMemWb : StMemRead;
      StMemWb:    w_next = StFetch;
      StMemWrite: w_next = bus.mem_ready ? StFetch : StMemWrite;
      StExecute:  w_next = StRWb;
      StRWb:      w_next = StFetch;
      StBranch:   w_next = StFetch;
      StJump:     w_next = StFetch;
      default:    w_next = StFetch;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUsrcA     = 1'b0;
    bus.ALUsrcB     = 2'b00;
    bus.ALUop       = 2'b00;
    bus.PCSource    = 2'b00;
    w_done          = 1'b0;
    bus.illegal     = 1'b0;
    // Reset masks every strobe so an abandoned instruction cannot write anything.
    if (!rst) begin
      case (r_state)
        StFetch: begin
          bus.MemRead = 1'b1;
          bus.ALUsrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        StDecode: begin
          bus.ALUsrcB = 2'b11;
          bus.illegal = !(bus.OP inside {OpR, OpLw, OpSw, OpBeq, OpJ});
        end
        StMemAddr: begin
          bus.ALUsrcA = 1'b1;
          bus.ALUsrcB = 2'b10;
        end
        StMemRead: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        StMemWb: begin
          bus.RegWrite = 1'b1;
          bus.MemToReg = 1'b1;
          w_done       = 1'b1;
        end
        StMemWrite: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
          w_done       = bus.mem_ready;
        end
        StExecute: begin
          bus.ALUsrcA = 1'b1;
          bus.ALUop   = 2'b10;
        end
        StRWb: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
          w_done       = 1'b1;
        end
        StBranch: begin
          bus.ALUsrcA     = 1'b1;
          bus.ALUop       = 2'b01;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
          w_done          = 1'b1;
        end
        StJump: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
          w_done       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state       = r_state;
  assign bus.instr_done  = w_done;
  assign bus.instr_count = r_count;
endmodule
